// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: branch opcodes, default PC vectors and PC-source selector.
package cpu_defs_pkg;

   typedef logic [5:0] opcode_t;

   localparam opcode_t OP_REGIMM = 6'b000001;
   localparam opcode_t OP_BEQ    = 6'b000100;
   localparam opcode_t OP_BNE    = 6'b000101;
   localparam opcode_t OP_BLEZ   = 6'b000110;
   localparam opcode_t OP_BGTZ   = 6'b000111;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
   localparam logic [31:0] JUMP_BASE_DEF = 32'h0000_3000;

   typedef enum logic [2:0] {
      SrcSeq,
      SrcExc,
      SrcEret,
      SrcBranch,
      SrcJump,
      SrcJr
   } pc_src_e;

   // J-type target before the JUMP_BASE offset: keep the PC region, word-align the index.
   function automatic logic [31:0] jump_index(input logic [3:0] region, input logic [25:0] idx);
      return {region, idx, 2'b00};
   endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Decode/operand inputs and PC outputs of the program-counter unit.
interface pc_seq_unit_if import cpu_defs_pkg::*; #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             en;
   logic             branch;
   logic             jump;
   logic             jr;
   opcode_t          op;
   logic [4:0]       rt;
   logic [15:0]      imm16;
   logic [25:0]      imm26;
   logic [XLEN-1:0]  busA;
   logic             zero;
   logic             exc_req;
   logic             eret;

   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus_4;
   logic [XLEN-1:0]  next_pc;
   logic [XLEN-1:0]  epc;
   logic             taken;
   logic [CNT_W-1:0] xfer_cnt;

   modport master (
      output en, branch, jump, jr, op, rt, imm16, imm26, busA, zero, exc_req, eret,
      input  pc, pc_plus_4, next_pc, epc, taken, xfer_cnt
   );

   modport slave (
      input  en, branch, jump, jr, op, rt, imm16, imm26, busA, zero, exc_req, eret,
      output pc, pc_plus_4, next_pc, epc, taken, xfer_cnt
   );
endinterface

// File: rtl/br_cond.sv
// Combinational branch-condition evaluator for the MIPS branch subset.
module br_cond import cpu_defs_pkg::*; #(
   parameter int unsigned XLEN = 32
) (
   input  opcode_t         op,
   input  logic [4:0]      rt,
   input  logic            zero,
   input  logic [XLEN-1:0] busA,
   output logic            cond_true
);

   logic is_neg;
   logic is_zero;

   assign is_neg  = busA[XLEN-1];
   assign is_zero = (busA == '0);

   always_comb begin
      cond_true = 1'b0;
      case (op)
         OP_BEQ:    cond_true = zero;
         OP_BNE:    cond_true = ~zero;
         OP_BGTZ:   cond_true = ~is_neg & ~is_zero;
         OP_BLEZ:   cond_true = is_neg | is_zero;
         // rt==0 selects BLTZ, any other rt is BGEZ
         OP_REGIMM: cond_true = (rt == 5'd0) ? is_neg : ~is_neg;
         default:   cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Registered program counter with branch/jump/JR redirect, stall, exception/EPC, ERET
// and a saturating count of taken control transfers.
module pc_seq_unit import cpu_defs_pkg::*; #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(RESET_VEC_DEF),
   parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(EXC_VEC_DEF),
   parameter logic [XLEN-1:0] JUMP_BASE   = XLEN'(JUMP_BASE_DEF),
   parameter bit              BR_FROM_PC4 = 1'b0,
   parameter int unsigned     CNT_W       = 16
) (
   input logic         clk,
   input logic         rst_n,
   pc_seq_unit_if.slave bus
);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  epc_q, epc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  pc_plus_4;
   logic [XLEN-1:0]  br_base;
   logic [XLEN-1:0]  br_off;
   logic [XLEN-1:0]  br_tgt;
   logic [XLEN-1:0]  jump_tgt;
   logic [XLEN-1:0]  jr_tgt;
   logic [XLEN-1:0]  next_pc;
   logic             taken;
   logic             cond_true;
   pc_src_e          src;

   br_cond #(
      .XLEN (XLEN)
   ) u_br_cond (
      .op        (bus.op),
      .rt        (bus.rt),
      .zero      (bus.zero),
      .busA      (bus.busA),
      .cond_true (cond_true)
   );

   assign pc_plus_4 = pc_q + XLEN'(4);
   assign br_base   = BR_FROM_PC4 ? pc_plus_4 : pc_q;
   assign br_off    = {{(XLEN-18){bus.imm16[15]}}, bus.imm16, 2'b00};
   assign br_tgt    = br_base + br_off;
   assign jump_tgt  = JUMP_BASE + XLEN'(jump_index(pc_q[31:28], bus.imm26));
   assign jr_tgt    = JUMP_BASE + bus.busA;

   always_comb begin
      src = SrcSeq;
      if (bus.exc_req)     src = SrcExc;
      else if (bus.eret)   src = SrcEret;
      else if (bus.branch) src = SrcBranch;
      else if (bus.jump)   src = SrcJump;
      else if (bus.jr)     src = SrcJr;
   end

   always_comb begin
      next_pc = pc_plus_4;
      taken   = 1'b0;
      case (src)
         SrcExc:    begin next_pc = EXC_VEC;  taken = 1'b1; end
         SrcEret:   begin next_pc = epc_q;    taken = 1'b1; end
         SrcJump:   begin next_pc = jump_tgt; taken = 1'b1; end
         SrcJr:     begin next_pc = jr_tgt;   taken = 1'b1; end
         SrcBranch: begin
            if (cond_true) begin
               next_pc = br_tgt;
               taken   = 1'b1;
            end
         end
         default:   ;
      endcase
   end

   // Exceptions bypass the stall; next_pc already resolves to EXC_VEC for them.
   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      cnt_d = cnt_q;
      if (bus.exc_req || bus.en) begin
         pc_d = next_pc;
         if (taken && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end
      if (bus.exc_req) epc_d = pc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         epc_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus_4 = pc_plus_4;
   assign bus.next_pc   = next_pc;
   assign bus.epc       = epc_q;
   assign bus.taken     = taken;
   assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed plus random checks of pc_seq_unit against a behavioural PC model.
module tb_pc_seq_unit;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pc_seq_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
   pc_seq_unit_if #(.XLEN(32), .CNT_W(3))  bus_s ();

   pc_seq_unit #(.XLEN(32), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Narrow-counter copy sharing the same stimulus, to reach saturation quickly.
   pc_seq_unit #(.XLEN(32), .CNT_W(3)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s)
   );

   assign bus_s.en      = bus.en;
   assign bus_s.branch  = bus.branch;
   assign bus_s.jump    = bus.jump;
   assign bus_s.jr      = bus.jr;
   assign bus_s.op      = bus.op;
   assign bus_s.rt      = bus.rt;
   assign bus_s.imm16   = bus.imm16;
   assign bus_s.imm26   = bus.imm26;
   assign bus_s.busA    = bus.busA;
   assign bus_s.zero    = bus.zero;
   assign bus_s.exc_req = bus.exc_req;
   assign bus_s.eret    = bus.eret;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   logic [31:0] m_epc;
   int unsigned m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.en      = 1'b0;
      bus.branch  = 1'b0;
      bus.jump    = 1'b0;
      bus.jr      = 1'b0;
      bus.op      = 6'd0;
      bus.rt      = 5'd0;
      bus.imm16   = 16'd0;
      bus.imm26   = 26'd0;
      bus.busA    = 32'd0;
      bus.zero    = 1'b0;
      bus.exc_req = 1'b0;
      bus.eret    = 1'b0;
   endtask

   function automatic void model_next(output logic [31:0] np, output bit tk);
      bit        c;
      int signed a;
      int signed off;
      a   = bus.busA;
      off = $signed(bus.imm16);
      off = off * 4;
      case (bus.op)
         6'd4:    c = bus.zero;
         6'd5:    c = !bus.zero;
         6'd7:    c = (a > 0);
         6'd6:    c = (a <= 0);
         6'd1:    c = (bus.rt == 5'd0) ? (a < 0) : (a >= 0);
         default: c = 1'b0;
      endcase
      np = m_pc + 32'd4;
      tk = 1'b0;
      if (bus.exc_req) begin
         np = 32'h0000_4180; tk = 1'b1;
      end else if (bus.eret) begin
         np = m_epc; tk = 1'b1;
      end else if (bus.branch) begin
         if (c) begin np = m_pc + off; tk = 1'b1; end
      end else if (bus.jump) begin
         np = 32'h0000_3000 + ((m_pc & 32'hF000_0000) + (32'(bus.imm26) << 2));
         tk = 1'b1;
      end else if (bus.jr) begin
         np = 32'h0000_3000 + bus.busA;
         tk = 1'b1;
      end
   endfunction

   task automatic check_regs(input string where);
      chk({where, "_pc"}, bus.pc, m_pc);
      chk({where, "_epc"}, bus.epc, m_epc);
      chk({where, "_cnt"}, 32'(bus.xfer_cnt), (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk({where, "_cnt_narrow"}, 32'(bus_s.xfer_cnt), (m_cnt > 7) ? 32'd7 : m_cnt);
   endtask

   task automatic clock_and_check();
      logic [31:0] np;
      bit          tk;
      #1;
      model_next(np, tk);
      chk("next_pc", bus.next_pc, np);
      chk("taken", 32'(bus.taken), 32'(tk));
      chk("pc_plus_4", bus.pc_plus_4, m_pc + 32'd4);
      @(posedge clk);
      if (bus.exc_req) begin
         m_epc = m_pc;
         m_pc  = np;
         m_cnt++;
      end else if (bus.en) begin
         m_pc = np;
         if (tk) m_cnt++;
      end
      #1;
      check_regs("edge");
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      m_pc  = 32'h0000_3000;
      m_epc = 32'd0;
      m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      rst_n = 1'b1;

      // Sequential fetch
      bus.en = 1'b1;
      repeat (3) clock_and_check();
      chk("seq_pc", bus.pc, 32'h0000_300C);
      clock_and_check();

      // BEQ backwards by one word from 0x3010
      bus.branch = 1'b1; bus.op = 6'b000100; bus.imm16 = 16'hFFFF; bus.zero = 1'b0;
      #1;
      chk("beq_nt_next", bus.next_pc, 32'h0000_3014);
      chk("beq_nt_taken", 32'(bus.taken), 32'd0);
      bus.zero = 1'b1;
      clock_and_check();
      chk("beq_pc", bus.pc, 32'h0000_300C);
      chk("beq_cnt", 32'(bus.xfer_cnt), 32'd1);

      // JR to 0x3020, then BLTZ/BGEZ on a negative operand
      idle(); bus.en = 1'b1; bus.jr = 1'b1; bus.busA = 32'h20;
      clock_and_check();
      idle(); bus.en = 1'b1; bus.branch = 1'b1; bus.op = 6'b000001; bus.rt = 5'd1;
      bus.busA = 32'h8000_0000; bus.imm16 = 16'd4;
      #1;
      chk("bgez_next", bus.next_pc, 32'h0000_3024);
      chk("bgez_taken", 32'(bus.taken), 32'd0);
      bus.rt = 5'd0;
      clock_and_check();
      chk("bltz_pc", bus.pc, 32'h0000_3030);

      // Jump and JR targets from 0x3000
      idle(); bus.en = 1'b1; bus.jr = 1'b1; bus.busA = 32'h0;
      clock_and_check();
      idle(); bus.en = 1'b1; bus.jump = 1'b1; bus.imm26 = 26'h10;
      clock_and_check();
      chk("jump_pc", bus.pc, 32'h0000_3040);
      idle(); bus.en = 1'b1; bus.jr = 1'b1; bus.busA = 32'h20;
      clock_and_check();
      chk("jr_pc", bus.pc, 32'h0000_3020);
      bus.busA = 32'h50;
      clock_and_check();

      // Exception while stalled, then ERET
      idle(); bus.exc_req = 1'b1;
      clock_and_check();
      chk("exc_pc", bus.pc, 32'h0000_4180);
      chk("exc_epc", bus.epc, 32'h0000_3050);
      idle(); bus.en = 1'b1; bus.eret = 1'b1;
      clock_and_check();
      chk("eret_pc", bus.pc, 32'h0000_3050);

      // Stall with a taken branch pending
      idle(); bus.branch = 1'b1; bus.op = 6'b000100; bus.zero = 1'b1; bus.imm16 = 16'd8;
      repeat (5) clock_and_check();
      chk("stall_pc", bus.pc, 32'h0000_3050);
      chk("stall_cnt", 32'(bus.xfer_cnt), 32'd9);
      chk("stall_cnt_narrow_sat", 32'(bus_s.xfer_cnt), 32'd7);
      chk("stall_taken", 32'(bus.taken), 32'd1);

      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      m_pc  = 32'h0000_3000;
      m_epc = 32'd0;
      m_cnt = 0;
      check_regs("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         idle();
         bus.en      = ($urandom_range(0, 3) != 0);
         bus.exc_req = ($urandom_range(0, 19) == 0);
         bus.eret    = ($urandom_range(0, 14) == 0);
         bus.branch  = ($urandom_range(0, 3) == 0);
         bus.jump    = ($urandom_range(0, 5) == 0);
         bus.jr      = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 5))
            0: bus.op = 6'b000001;
            1: bus.op = 6'b000100;
            2: bus.op = 6'b000101;
            3: bus.op = 6'b000110;
            4: bus.op = 6'b000111;
            default: bus.op = 6'($urandom);
         endcase
         bus.rt    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
         bus.imm16 = 16'($urandom);
         bus.imm26 = 26'($urandom);
         bus.zero  = 1'($urandom);
         case ($urandom_range(0, 3))
            0: bus.busA = 32'd0;
            1: bus.busA = 32'h8000_0000;
            2: bus.busA = 32'($urandom_range(0, 255));
            default: bus.busA = $urandom;
         endcase
         clock_and_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
